// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the command-driven I2C master.
package i2c_pkg;

    // Transaction phases of the master sequencer.
    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        RD_NACK,
        STOP,
        DONE
    } i2c_mstate_t;

    localparam logic I2C_RW_WRITE         = 1'b0;
    localparam logic I2C_RW_READ          = 1'b1;
    localparam int   I2C_QUARTERS_PER_BIT = 4;

endpackage

// File: rtl/i2c_qtick.sv
`timescale 1ns/1ps
// Quarter-period timebase: divides clk by CLK_DIV and tracks which of the
// four SCL quarters of a bit is current. 'hold' freezes it while a slave
// stretches SCL.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] q
);
    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    q_reg;

    assign tick = (cnt_reg == CNT_LAST) && !hold;
    assign q    = q_reg;

    // Divider counter and quarter index; a clear restarts at quarter 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            q_reg   <= 2'd0;
        end else if (clear) begin
            cnt_reg <= '0;
            q_reg   <= 2'd0;
        end else if (!hold) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                q_reg   <= q_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
`timescale 1ns/1ps
// Single-byte I2C master: accepts one command, runs START/address/data/
// ACK/STOP on the open-drain bus and returns one response.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SCL_out_en,
    output logic       SDA_out_en,
    input  logic       SCL_in,
    input  logic       SDA_in
);
    localparam logic [1:0] Q_LAST = 2'(I2C_QUARTERS_PER_BIT - 1);

    i2c_mstate_t state_reg, state_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  addr_reg, wdata_reg;
    logic [7:0]  rdata_reg, rdata_next;
    logic        nack_reg, nack_next;
    logic        scl_en_reg, scl_en_next;
    logic        sda_en_reg, sda_en_next;
    logic        cmd_ready_reg, busy_reg, rsp_valid_reg, rsp_nack_reg;
    logic [7:0]  rsp_rdata_reg;
    logic        accept, tick, hold, bit_end;
    logic [1:0]  q, q_next;
    logic [7:0]  addr_msb, wdata_msb;

    assign accept  = cmd_valid && cmd_ready_reg;
    assign bit_end = tick && (q == Q_LAST);
    // Stretching only matters while SCL is meant to be released.
    assign hold    = q[1] && !SCL_in && (state_reg != IDLE) && (state_reg != DONE);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .hold  (hold),
        .tick  (tick),
        .q     (q)
    );

    // Bit-reversed copies so the bit counter directly indexes MSB first.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_msb
            assign addr_msb[gi]  = addr_reg[7-gi];
            assign wdata_msb[gi] = wdata_reg[7-gi];
        end
    endgenerate

    // Next-state logic: phases advance only at the end of a bit (q3 tick).
    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        rdata_next = rdata_reg;
        nack_next  = nack_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    bit_next   = 3'd0;
                    rdata_next = 8'h00;
                    nack_next  = 1'b0;
                end
            end
            START:     if (bit_end) state_next = ADDR;
            ADDR: begin
                if (bit_end) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                if (bit_end) begin
                    if (SDA_in) begin
                        nack_next  = 1'b1;
                        state_next = STOP;
                    end else begin
                        state_next = (addr_reg[0] == I2C_RW_WRITE) ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (bit_end) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = WRITE_ACK;
                end
            end
            WRITE_ACK: begin
                if (bit_end) begin
                    if (SDA_in) nack_next = 1'b1;
                    state_next = STOP;
                end
            end
            READ: begin
                if (bit_end) begin
                    rdata_next = {rdata_reg[6:0], SDA_in};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = RD_NACK;
                end
            end
            RD_NACK:   if (bit_end) state_next = STOP;
            STOP:      if (bit_end) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Bus enables are computed from the upcoming state and quarter so the
    // registered pins line up with the quarter counter.
    always_comb begin
        q_next      = accept ? 2'd0 : (tick ? q + 2'd1 : q);
        scl_en_next = 1'b1;
        sda_en_next = 1'b1;
        case (state_next)
            START:  sda_en_next = !q_next[1];
            ADDR: begin
                scl_en_next = q_next[1];
                sda_en_next = addr_msb[bit_next];
            end
            WRITE: begin
                scl_en_next = q_next[1];
                sda_en_next = wdata_msb[bit_next];
            end
            ADDR_ACK, WRITE_ACK, READ, RD_NACK: scl_en_next = q_next[1];
            STOP: begin
                scl_en_next = (q_next != 2'd0);
                sda_en_next = q_next[1];
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_reg       <= 3'd0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            rdata_reg     <= 8'h00;
            nack_reg      <= 1'b0;
            scl_en_reg    <= 1'b1;
            sda_en_reg    <= 1'b1;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_nack_reg  <= 1'b0;
            rsp_rdata_reg <= 8'h00;
        end else begin
            state_reg     <= state_next;
            bit_reg       <= bit_next;
            rdata_reg     <= rdata_next;
            nack_reg      <= nack_next;
            scl_en_reg    <= scl_en_next;
            sda_en_reg    <= sda_en_next;
            cmd_ready_reg <= (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
            rsp_valid_reg <= (state_next == DONE);
            if (accept) begin
                addr_reg  <= {cmd_addr, cmd_rw};
                wdata_reg <= cmd_wdata;
            end
            if (state_next == DONE) begin
                rsp_nack_reg  <= nack_reg;
                rsp_rdata_reg <= (addr_reg[0] == I2C_RW_READ) ? rdata_reg : 8'h00;
            end
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign busy       = busy_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_nack   = rsp_nack_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign SCL_out_en = scl_en_reg;
    assign SDA_out_en = sda_en_reg;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
`timescale 1ns/1ps
// Directed bench for i2c_master_ctrl with a behavioural single-byte slave.
module tb_i2c_master_ctrl;
    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] SLV_ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata, rsp_rdata;
    logic       rsp_valid, rsp_nack, busy;
    logic       SCL_out_en, SDA_out_en, SCL_in, SDA_in;
    logic       tb_scl_low;
    logic       slv_sda_en;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign SCL_in = SCL_out_en & ~tb_scl_low;
    assign SDA_in = SDA_out_en & slv_sda_en;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_nack   (rsp_nack),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .SCL_out_en (SCL_out_en),
        .SDA_out_en (SDA_out_en),
        .SCL_in     (SCL_in),
        .SDA_in     (SDA_in)
    );

    // Behavioural slave at SLV_ADDR: stores a written byte in slv_mem,
    // returns slv_tx on reads.
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WR, S_RD} sst_t;
    sst_t       s_state;
    int         s_bit;
    logic [7:0] s_sr, slv_mem, slv_tx;
    logic       s_rw, prev_scl, prev_sda;

    always @(posedge clk) begin
        if (reset) begin
            s_state    <= S_IDLE;
            s_bit      <= 0;
            slv_sda_en <= 1'b1;
            prev_scl   <= 1'b1;
            prev_sda   <= 1'b1;
        end else begin
            prev_scl <= SCL_in;
            prev_sda <= SDA_in;
            if (prev_scl && SCL_in && prev_sda && !SDA_in) begin
                s_state    <= S_ADDR;
                s_bit      <= 0;
                slv_sda_en <= 1'b1;
            end else if (prev_scl && SCL_in && !prev_sda && SDA_in) begin
                s_state    <= S_IDLE;
                slv_sda_en <= 1'b1;
            end else if (!prev_scl && SCL_in) begin
                if (s_bit < 8) s_sr <= {s_sr[6:0], SDA_in};
                s_bit <= s_bit + 1;
            end else if (prev_scl && !SCL_in) begin
                case (s_state)
                    S_ADDR: begin
                        if (s_bit == 8) begin
                            if (s_sr[7:1] == SLV_ADDR) begin
                                slv_sda_en <= 1'b0;
                                s_rw       <= s_sr[0];
                            end else begin
                                s_state <= S_IDLE;
                            end
                        end else if (s_bit == 9) begin
                            s_bit <= 0;
                            if (s_rw) begin
                                s_state    <= S_RD;
                                slv_sda_en <= slv_tx[7];
                            end else begin
                                s_state    <= S_WR;
                                slv_sda_en <= 1'b1;
                            end
                        end
                    end
                    S_WR: begin
                        if (s_bit == 8) begin
                            slv_mem    <= s_sr;
                            slv_sda_en <= 1'b0;
                        end else if (s_bit == 9) begin
                            s_bit      <= 0;
                            slv_sda_en <= 1'b1;
                        end
                    end
                    S_RD: begin
                        if (s_bit >= 1 && s_bit <= 7) slv_sda_en <= slv_tx[7-s_bit];
                        else if (s_bit == 8) slv_sda_en <= 1'b1;
                        else if (s_bit == 9) begin
                            s_state    <= S_IDLE;
                            slv_sda_en <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue one command and observe it until rsp_valid (bounded).
    // lat = negedges from accept to the rsp_valid cycle; -1 if none.
    task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input logic keep_valid, input int stretch_at,
                           output int lat, output int waitn, output int rise40,
                           output int rise_all, output int sda_low_rd, output int ready_busy);
        logic ps;
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        waitn = 0;
        while (!cmd_ready && waitn < 1000) begin
            @(negedge clk);
            waitn++;
        end
        lat = -1; rise40 = 0; rise_all = 0; sda_low_rd = 0; ready_busy = 0;
        ps = SCL_out_en;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = keep_valid;
            if (stretch_at > 0 && n == stretch_at) tb_scl_low = 1'b1;
            if (stretch_at > 0 && n == stretch_at + 10) tb_scl_low = 1'b0;
            if (SCL_out_en && !ps) begin
                rise_all++;
                if (n <= 40 * CLK_DIV) rise40++;
            end
            ps = SCL_out_en;
            if (!SDA_out_en && n > 40 * CLK_DIV && n <= 76 * CLK_DIV) sda_low_rd++;
            if (cmd_ready || !busy) ready_busy++;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        tb_scl_low = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (SCL_out_en !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", SCL_out_en); end
        checks++; if (SDA_out_en !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", SDA_out_en); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_nack !== 1'b0)   begin errors++; $display("FAIL reset_rsp_nack got %b want 0", rsp_nack); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rsp_rdata); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_write();
        int lat, w, r40, ra, sl, rb;
        run_cmd(7'h42, 1'b0, 8'hA5, 1'b0, 0, lat, w, r40, ra, sl, rb);
        checks++; if (lat !== 321)        begin errors++; $display("FAIL write_latency got %0d want 321", lat); end
        checks++; if (rsp_nack !== 1'b0)  begin errors++; $display("FAIL write_nack got %b want 0", rsp_nack); end
        checks++; if (slv_mem !== 8'hA5)  begin errors++; $display("FAIL write_mem got %h want a5", slv_mem); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata got %h want 00", rsp_rdata); end
        checks++; if (rb !== 0)           begin errors++; $display("FAIL write_busy_ready got %0d bad cycles want 0", rb); end
        $display("write 0x42<-a5: latency %0d nack %b mem %h", lat, rsp_nack, slv_mem);
    endtask

    task automatic test_wrong_addr();
        int lat, w, r40, ra, sl, rb;
        run_cmd(7'h13, 1'b0, 8'h5A, 1'b0, 0, lat, w, r40, ra, sl, rb);
        checks++; if (lat !== 177)       begin errors++; $display("FAIL nack_latency got %0d want 177", lat); end
        checks++; if (rsp_nack !== 1'b1) begin errors++; $display("FAIL nack_flag got %b want 1", rsp_nack); end
        checks++; if (r40 !== 9)         begin errors++; $display("FAIL nack_scl_pulses got %0d want 9", r40); end
        checks++; if (ra !== 10)         begin errors++; $display("FAIL nack_scl_total got %0d want 10", ra); end
        $display("wrong addr 0x13: latency %0d nack %b scl pulses %0d", lat, rsp_nack, r40);
    endtask

    task automatic test_read();
        int lat, w, r40, ra, sl, rb;
        slv_tx = 8'h3C;
        run_cmd(7'h42, 1'b1, 8'h00, 1'b0, 0, lat, w, r40, ra, sl, rb);
        checks++; if (lat !== 321)         begin errors++; $display("FAIL read_latency got %0d want 321", lat); end
        checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL read_data got %h want 3c", rsp_rdata); end
        checks++; if (rsp_nack !== 1'b0)   begin errors++; $display("FAIL read_nack got %b want 0", rsp_nack); end
        checks++; if (sl !== 0)            begin errors++; $display("FAIL read_sda_released got %0d low cycles want 0", sl); end
        $display("read 0x42: latency %0d rdata %h nack %b", lat, rsp_rdata, rsp_nack);
    endtask

    task automatic test_stretch();
        int lat, w, r40, ra, sl, rb;
        // q2 of address bit 3 starts at cycle 1 + (4 + 4*3 + 2) * CLK_DIV = 73
        run_cmd(7'h42, 1'b0, 8'h6B, 1'b0, 73, lat, w, r40, ra, sl, rb);
        checks++; if (lat !== 331)        begin errors++; $display("FAIL stretch_latency got %0d want 331", lat); end
        checks++; if (rsp_nack !== 1'b0)  begin errors++; $display("FAIL stretch_nack got %b want 0", rsp_nack); end
        checks++; if (slv_mem !== 8'h6B)  begin errors++; $display("FAIL stretch_mem got %h want 6b", slv_mem); end
        $display("stretch write 0x42<-6b: latency %0d mem %h", lat, slv_mem);
    endtask

    task automatic test_reset_mid();
        int lat, w, r40, ra, sl, rb, rsp_seen;
        @(negedge clk);
        cmd_addr = 7'h42; cmd_rw = 1'b0; cmd_wdata = 8'h96; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        // WRITE bit 4 occupies cycles 225..240; q0 (SCL low) is 225..228
        for (int n = 1; n <= 226; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
        end
        checks++; if (SCL_out_en !== 1'b0) begin errors++; $display("FAIL mid_scl_before got %b want 0", SCL_out_en); end
        checks++; if (SDA_out_en !== 1'b0) begin errors++; $display("FAIL mid_sda_before got %b want 0", SDA_out_en); end
        reset = 1'b1;
        #1;
        checks++; if (SCL_out_en !== 1'b1) begin errors++; $display("FAIL mid_scl_reset got %b want 1", SCL_out_en); end
        checks++; if (SDA_out_en !== 1'b1) begin errors++; $display("FAIL mid_sda_reset got %b want 1", SDA_out_en); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy_reset got %b want 0", busy); end
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", cmd_ready); end
        repeat (30) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d pulses want 0", rsp_seen); end
        run_cmd(7'h42, 1'b0, 8'h5A, 1'b0, 0, lat, w, r40, ra, sl, rb);
        checks++; if (lat !== 321)       begin errors++; $display("FAIL mid_next_latency got %0d want 321", lat); end
        checks++; if (slv_mem !== 8'h5A) begin errors++; $display("FAIL mid_next_mem got %h want 5a", slv_mem); end
        $display("reset mid-write: follow-up latency %0d mem %h", lat, slv_mem);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, w1, w2, r40, ra, sl, rb1, rb2;
        logic rdy_done;
        slv_tx = 8'h77;
        run_cmd(7'h42, 1'b0, 8'h11, 1'b1, 0, lat1, w1, r40, ra, sl, rb1);
        rdy_done = cmd_ready;
        run_cmd(7'h42, 1'b1, 8'h00, 1'b1, 0, lat2, w2, r40, ra, sl, rb2);
        cmd_valid = 1'b0;
        checks++; if (lat1 !== 321)       begin errors++; $display("FAIL b2b_lat1 got %0d want 321", lat1); end
        checks++; if (rb1 !== 0)          begin errors++; $display("FAIL b2b_ignored_busy got %0d bad cycles want 0", rb1); end
        checks++; if (rdy_done !== 1'b0)  begin errors++; $display("FAIL b2b_ready_done got %b want 0", rdy_done); end
        checks++; if (w2 !== 0)           begin errors++; $display("FAIL b2b_accept_gap got %0d want 0", w2); end
        checks++; if (slv_mem !== 8'h11)  begin errors++; $display("FAIL b2b_mem got %h want 11", slv_mem); end
        checks++; if (lat2 !== 321)       begin errors++; $display("FAIL b2b_lat2 got %0d want 321", lat2); end
        checks++; if (rsp_rdata !== 8'h77) begin errors++; $display("FAIL b2b_rdata got %h want 77", rsp_rdata); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got busy %b want 0", busy); end
        $display("back-to-back: lat %0d/%0d gap %0d rdata %h", lat1, lat2, w2, rsp_rdata);
    endtask

    initial begin
        cmd_valid  = 1'b0;
        cmd_addr   = 7'h00;
        cmd_rw     = 1'b0;
        cmd_wdata  = 8'h00;
        tb_scl_low = 1'b0;
        slv_tx     = 8'h00;
        slv_mem    = 8'h00;
        s_sr       = 8'h00;
        s_rw       = 1'b0;
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Command-driven I2C master that sequences single-byte write and read transactions onto the open-drain bus shared with `i2c_slave` instances. It takes one command (7-bit address, R/W, write byte) over a valid/ready handshake and generates START, address, data, ACK and STOP phases from a programmable quarter-period tick. It samples the slave's ACK and read data, and returns one response per command. It honours SCL clock stretching.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCL quarter-period; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_addr`  in  7  target slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_wdata`  in  8  write byte; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse when the transaction is complete.
- `rsp_nack`  out  1  valid with `rsp_valid`; 1 = address or data NACK.
- `rsp_rdata`  out  8  read byte; valid with `rsp_valid` for reads, 0 otherwise.
- `busy`  out  1  high from command accept until the `rsp_valid` cycle inclusive.
- `SCL_out_en`  out  1  open-drain enable: 0 pulls SCL low, 1 releases it.
- `SDA_out_en`  out  1  open-drain enable: 0 pulls SDA low, 1 releases it.
- `SCL_in`  in  1  sensed SCL line, used for stretching.
- `SDA_in`  in  1  sensed SDA line.

## Operation
- Reset values: `SCL_out_en`=1, `SDA_out_en`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_nack`=0, `rsp_rdata`=0, `busy`=0, state IDLE.
- On accept, register `{cmd_addr, cmd_rw}` as the address byte and `cmd_wdata`. Clear the quarter counter.
- Each bit is 4 quarters:
  - q0 and q1: SCL low. SDA is set to the bit value at the start of q0.
  - q2 and q3: SCL released.
  - SDA_in is sampled in the last clk cycle of q3.
- States:
  - IDLE → START on accept.
  - START, 4 quarters: two quarters with SCL and SDA both released, then two quarters with SDA low and SCL released.
  - → ADDR: 8 bits, MSB first.
  - → ADDR_ACK: 1 bit, SDA released. If the sample is 1 (NACK), set `nack` and go to STOP.
  - ADDR_ACK → WRITE if rw=0, or READ if rw=1.
  - WRITE: 8 bits of wdata, MSB first → WRITE_ACK. WRITE_ACK samples ACK, with NACK setting `nack` as in ADDR_ACK, then goes to STOP.
  - READ: 8 bits, SDA released; sampled bits shift MSB first into rdata. → RD_NACK: 1 bit, master releases SDA (single-byte read) → STOP.
  - STOP, 4 quarters:
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2 and q3: SCL and SDA both released.
  - STOP → DONE. DONE lasts one cycle: `rsp_valid`=1, then IDLE.
- Bit counter is 3 bits and wraps 7→0 on the phase change.
- Stretching: in q2 and q3, the quarter counter holds while `SCL_in`=0. There is no timeout.
- Reset mid-transaction:
  - Both enables release immediately (asynchronous).
  - No response is issued.
  - `cmd_ready`=1 after reset deasserts.

## Timing
- Quarter tick: the counter runs 0..CLK_DIV-1, width $clog2(CLK_DIV). The tick is at CLK_DIV-1.
- Latency, without stretching, from the accept cycle to the `rsp_valid` cycle:
  - full transaction (ACK): 80·CLK_DIV + 1 cycles;
  - address NACK: 44·CLK_DIV + 1 cycles.
- Each stretched clk cycle adds exactly one cycle of latency.
- `cmd_ready` is 0 from the cycle after accept through DONE. It returns to 1 the cycle after `rsp_valid`. Back-to-back accept is possible then.
- `cmd_valid` during busy is ignored and is not queued.
- Outputs are registered. `SDA_out_en` never changes while SCL is released, except in START q2 and STOP q2.

## Structure
- `i2c_pkg`:
  - `i2c_mstate_t` enum: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, RD_NACK, STOP, DONE;
  - `I2C_RW_WRITE`=0, `I2C_RW_READ`=1;
  - `I2C_QUARTERS_PER_BIT`=4.
- Sub-module `i2c_qtick` generates the quarter tick and quarter index:
  - inputs: `clk`, `reset`, `clear`, `hold`;
  - outputs: `tick`, `q[1:0]`;
  - `hold` is driven by `!SCL_in` during q2 and q3.
- Top module: FSM, shift register, bit counter and response registers.

## Test plan
- Write to `i2c_slave` (ADDR=0x42):
  - stimulus: cmd_addr 0x42, rw 0, wdata 0xA5, CLK_DIV 4;
  - required: `rsp_valid` 321 cycles after accept, `rsp_nack`=0, slave `mem`=0xA5.
- Wrong address:
  - stimulus: cmd_addr 0x13, rw 0;
  - required: `rsp_nack`=1 at 177 cycles; SCL toggles exactly 9 times after START; no data phase.
- Read:
  - stimulus: a bench slave model returns 0x3C;
  - required: `rsp_rdata`=0x3C, `rsp_nack`=0, SDA released during RD_NACK.
- Clock stretch:
  - stimulus: hold `SCL_in` low 10 extra cycles in the q2 of address bit 3;
  - required: `rsp_valid` at 331 cycles; data intact.
- Reset mid-transaction:
  - stimulus: assert `reset` during WRITE bit 4;
  - required: `SCL_out_en`=`SDA_out_en`=1 in the same cycle, no `rsp_valid`, `cmd_ready`=1 after release; the next command completes normally.
- Back-to-back:
  - stimulus: hold `cmd_valid` high with two commands;
  - required: the second is accepted the cycle after the first `rsp_valid`; `cmd_valid` asserted during busy is not accepted.
